// File: rtl/mem_req_rr_arbiter_pkg.sv
// Request bundle types shared by the memory-request arbiter and its users.
package mem_req_pkg;

  localparam int ADDR_W = 40;
  localparam int TAG_W  = 10;
  localparam int CMD_W  = 5;
  localparam int TYP_W  = 3;
  localparam int DATA_W = 64;
  localparam int REQ_W  = ADDR_W + TAG_W + CMD_W + TYP_W + 2 + DATA_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [TAG_W-1:0]  tag;
    logic [CMD_W-1:0]  cmd;
    logic [TYP_W-1:0]  typ;
    logic              kill;
    logic              phys;
    logic [DATA_W-1:0] data;
  } mem_req_t;

endpackage

// File: rtl/mem_req_rr_arbiter_if.sv
// Arbiter request/response bundle: NUM_IN requesters in, one registered port out.
interface mem_req_rr_arbiter_if #(
  parameter int NUM_IN = 2,
  parameter int IDX_W  = $clog2(NUM_IN)
);
  import mem_req_pkg::*;

  logic [NUM_IN-1:0]           io_in_valid;
  logic [NUM_IN-1:0]           io_in_ready;
  mem_req_t [NUM_IN-1:0]       io_in_bits;
  logic                        io_out_valid;
  logic                        io_out_ready;
  mem_req_t                    io_out_bits;
  logic [IDX_W-1:0]            io_chosen;

  modport master (
    input  io_in_valid, io_in_bits, io_out_ready,
    output io_in_ready, io_out_valid, io_out_bits, io_chosen
  );

  modport slave (
    output io_in_valid, io_in_bits, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_bits, io_chosen
  );

endinterface

// File: rtl/mem_req_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit after 'last', wrapping.
module rr_pick #(
  parameter int NUM_IN = 2,
  parameter int IDX_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  last,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              any
);

  // Scan from farthest to nearest so the nearest candidate after 'last' wins.
  always_comb begin
    logic [IDX_W-1:0] pos_v;
    logic             hit_v;
    grant_idx = {IDX_W{1'b0}};
    any       = 1'b0;
    for (int k = NUM_IN; k >= 1; k--) begin
      pos_v     = IDX_W'((int'(last) + k) % NUM_IN);
      hit_v     = req[pos_v];
      grant_idx = hit_v ? pos_v : grant_idx;
      any       = any | hit_v;
    end
  end

endmodule

// File: rtl/mem_req_rr_arbiter.sv
// Round-robin memory-request arbiter with a one-entry output register.
// Optional stall counters are built when MEM_REQ_ARB_PERF_EN is defined.
module mem_req_rr_arbiter
  import mem_req_pkg::*;
#(
  parameter int NUM_IN = 2,
  parameter int IDX_W  = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  mem_req_rr_arbiter_if.master     io
`ifdef MEM_REQ_ARB_PERF_EN
  ,
  input  logic                     perf_clr,
  output logic [NUM_IN-1:0][31:0]  perf_stall_cnt
`endif
);

  logic              out_valid_r;
  mem_req_t          out_bits_r;
  logic [IDX_W-1:0]  out_chosen_r;
  logic [IDX_W-1:0]  last_grant_r;

  logic              can_load_s;
  logic [IDX_W-1:0]  grant_idx_s;
  logic              any_s;
  logic [NUM_IN-1:0] in_ready_s;
  logic              fire_s;

  rr_pick #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req       (io.io_in_valid),
    .last      (last_grant_r),
    .grant_idx (grant_idx_s),
    .any       (any_s)
  );

  assign can_load_s = !out_valid_r || io.io_out_ready;

  // One-hot accept; reset_n gating keeps ready low while the block is in reset.
  always_comb begin
    in_ready_s = {NUM_IN{1'b0}};
    for (int i = 0; i < NUM_IN; i++) begin
      in_ready_s[i] = reset_n && can_load_s && any_s &&
                      (grant_idx_s == IDX_W'(i)) && io.io_in_valid[i];
    end
  end

  assign fire_s         = |in_ready_s;
  assign io.io_in_ready = in_ready_s;
  assign io.io_out_valid = out_valid_r;
  assign io.io_out_bits  = out_bits_r;
  assign io.io_chosen    = out_chosen_r;

  // Output register and pointer; a fire overrides a same-cycle drain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r  <= 1'b0;
      out_bits_r   <= '0;
      out_chosen_r <= {IDX_W{1'b0}};
      last_grant_r <= IDX_W'(NUM_IN - 1);
    end else if (fire_s) begin
      out_valid_r  <= 1'b1;
      out_bits_r   <= io.io_in_bits[grant_idx_s];
      out_chosen_r <= grant_idx_s;
      last_grant_r <= grant_idx_s;
    end else if (out_valid_r && io.io_out_ready) begin
      out_valid_r  <= 1'b0;
    end else begin
      out_valid_r  <= out_valid_r;
    end
  end

`ifdef MEM_REQ_ARB_PERF_EN
  for (genvar g = 0; g < NUM_IN; g++) begin : g_perf
    // Saturating per-requester stall counter; clear wins over increment.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        perf_stall_cnt[g] <= 32'h0000_0000;
      end else if (perf_clr) begin
        perf_stall_cnt[g] <= 32'h0000_0000;
      end else if (io.io_in_valid[g] && !in_ready_s[g] &&
                   (perf_stall_cnt[g] != 32'hFFFF_FFFF)) begin
        perf_stall_cnt[g] <= perf_stall_cnt[g] + 32'h0000_0001;
      end else begin
        perf_stall_cnt[g] <= perf_stall_cnt[g];
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_req_rr_arbiter.sv
// Scoreboard bench for mem_req_rr_arbiter (NUM_IN=2); perf test needs MEM_REQ_ARB_PERF_EN.
module tb_mem_req_rr_arbiter;
  import mem_req_pkg::*;

  localparam int NUM_IN = 2;
  localparam int IDX_W  = 1;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    mem_req_t         bits;
  } exp_t;

  logic clk;
  logic reset_n;
  logic perf_clr;
  logic [NUM_IN-1:0][31:0] perf_stall_cnt;

  int n_tests;
  int n_fail;
  exp_t exp_q[$];
  exp_t mon_e;

  mem_req_t p0;
  mem_req_t p1;

  mem_req_rr_arbiter_if #(.NUM_IN(NUM_IN), .IDX_W(IDX_W)) ifc ();

  mem_req_rr_arbiter #(.NUM_IN(NUM_IN), .IDX_W(IDX_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (ifc)
`ifdef MEM_REQ_ARB_PERF_EN
    ,
    .perf_clr       (perf_clr),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mem_req_t mk_req(input logic [39:0] a, input logic [63:0] d);
    mem_req_t r;
    r.addr = a;
    r.tag  = a[9:0];
    r.cmd  = a[4:0];
    r.typ  = a[2:0];
    r.kill = a[3];
    r.phys = a[4];
    r.data = d;
    return r;
  endfunction

  task automatic push(input int idx, input mem_req_t b);
    exp_t e;
    e.idx  = IDX_W'(idx);
    e.bits = b;
    exp_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int k;
    for (k = 0; k < 20; k++) begin
      if (exp_q.size() == 0) break;
      next_cycle();
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Scoreboard: every accepted output beat must match the oldest expectation.
  always begin
    @(negedge clk);
    #3;
    if (reset_n && ifc.io_out_valid && ifc.io_out_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: beat chosen=%0d addr=%h, none expected",
                 ifc.io_chosen, ifc.io_out_bits.addr);
      end else begin
        mon_e = exp_q.pop_front();
        if (ifc.io_chosen !== mon_e.idx || ifc.io_out_bits !== mon_e.bits) begin
          n_fail++;
          $display("FAIL sb_beat: got chosen=%0d bits=%h, required chosen=%0d bits=%h",
                   ifc.io_chosen, ifc.io_out_bits, mon_e.idx, mon_e.bits);
        end
      end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    perf_clr = 1'b0;
    ifc.io_in_valid = 2'b11;
    ifc.io_out_ready = 1'b1;
    ifc.io_in_bits[0] = mk_req(40'h0_0000_1000, 64'h1111_0000_0000_0000);
    ifc.io_in_bits[1] = mk_req(40'h0_0000_2000, 64'h2222_0000_0000_0000);
    repeat (3) next_cycle();
    #1;
    n_tests++;
    if (ifc.io_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, required 0", ifc.io_out_valid); end
    n_tests++;
    if (ifc.io_out_bits !== '0) begin n_fail++; $display("FAIL rst_bits: got %h, required 0", ifc.io_out_bits); end
    n_tests++;
    if (ifc.io_chosen !== 1'b0) begin n_fail++; $display("FAIL rst_chosen: got %0d, required 0", ifc.io_chosen); end
    n_tests++;
    if (ifc.io_in_ready !== 2'b00) begin n_fail++; $display("FAIL rst_ready: got %b, required 00", ifc.io_in_ready); end
  endtask

  task automatic test_alternate();
    logic [1:0] exp_rdy;
    next_cycle();
    reset_n = 1'b1;
    p0 = ifc.io_in_bits[0];
    p1 = ifc.io_in_bits[1];
    for (int k = 0; k < 4; k++) begin
      if (k > 0) next_cycle();
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      push(k % 2, (k % 2 == 0) ? p0 : p1);
      #1;
      n_tests++;
      if (ifc.io_in_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL alt_ready[%0d]: got %b, required %b", k, ifc.io_in_ready, exp_rdy);
      end
    end
    next_cycle();
    ifc.io_in_valid = 2'b00;
    wait_drain();
  endtask

  task automatic test_single();
    next_cycle();
    ifc.io_in_valid = 2'b10;
    for (int k = 0; k < 3; k++) begin
      ifc.io_in_bits[1] = mk_req(40'h0_0000_0100 + 40'(8 * k), 64'h5555_0000_0000_0000 + 64'(k));
      push(1, ifc.io_in_bits[1]);
      #1;
      n_tests++;
      if (ifc.io_in_ready !== 2'b10) begin
        n_fail++;
        $display("FAIL single_ready[%0d]: got %b, required 10", k, ifc.io_in_ready);
      end
      if (k > 0) begin
        n_tests++;
        if (ifc.io_out_valid !== 1'b1 || ifc.io_chosen !== 1'b1) begin
          n_fail++;
          $display("FAIL single_stream[%0d]: got valid=%b chosen=%0d, required 1/1",
                   k, ifc.io_out_valid, ifc.io_chosen);
        end
      end
      next_cycle();
    end
    ifc.io_in_valid = 2'b00;
    #1;
    n_tests++;
    if (ifc.io_out_valid !== 1'b1) begin n_fail++; $display("FAIL single_last: got %b, required 1", ifc.io_out_valid); end
    wait_drain();
  endtask

  task automatic test_backpressure();
    next_cycle();
    p0 = mk_req(40'h0_0000_3000, 64'h3333_0000_0000_0003);
    p1 = mk_req(40'h0_0000_4000, 64'h4444_0000_0000_0004);
    ifc.io_in_bits[0] = p0;
    ifc.io_in_bits[1] = p1;
    ifc.io_out_ready = 1'b0;
    ifc.io_in_valid = 2'b11;
    push(0, p0);
    #1;
    n_tests++;
    if (ifc.io_in_ready !== 2'b01) begin n_fail++; $display("FAIL bp_first: got %b, required 01", ifc.io_in_ready); end
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      #1;
      n_tests++;
      if (ifc.io_in_ready !== 2'b00 || ifc.io_out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_stall[%0d]: got ready=%b valid=%b, required 00/1",
                 k, ifc.io_in_ready, ifc.io_out_valid);
      end
    end
    next_cycle();
    ifc.io_out_ready = 1'b1;
    push(1, p1);
    #1;
    n_tests++;
    if (ifc.io_in_ready !== 2'b10) begin n_fail++; $display("FAIL bp_release: got %b, required 10", ifc.io_in_ready); end
    next_cycle();
    ifc.io_in_valid = 2'b00;
    wait_drain();
  endtask

  task automatic test_payload();
    mem_req_t pl;
    pl.addr = 40'hAB_CDEF_0123;
    pl.tag  = 10'h3FF;
    pl.cmd  = 5'h1F;
    pl.typ  = 3'h7;
    pl.kill = 1'b1;
    pl.phys = 1'b1;
    pl.data = 64'hDEADBEEF_CAFEF00D;
    next_cycle();
    ifc.io_in_bits[0] = pl;
    ifc.io_in_valid = 2'b01;
    push(0, pl);
    #1;
    n_tests++;
    if (ifc.io_in_ready !== 2'b01) begin n_fail++; $display("FAIL pay_ready: got %b, required 01", ifc.io_in_ready); end
    next_cycle();
    ifc.io_in_valid = 2'b00;
    #1;
    n_tests++;
    if (ifc.io_out_valid !== 1'b1 || ifc.io_out_bits !== pl) begin
      n_fail++;
      $display("FAIL pay_bits: got valid=%b bits=%h, required 1/%h", ifc.io_out_valid, ifc.io_out_bits, pl);
    end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    next_cycle();
    ifc.io_out_ready = 1'b0;
    ifc.io_in_valid = 2'b11;
    #1;
    n_tests++;
    if (ifc.io_in_ready !== 2'b10) begin n_fail++; $display("FAIL rm_pre_ready: got %b, required 10", ifc.io_in_ready); end
    next_cycle();
    #1;
    n_tests++;
    if (ifc.io_out_valid !== 1'b1) begin n_fail++; $display("FAIL rm_full: got %b, required 1", ifc.io_out_valid); end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (ifc.io_out_valid !== 1'b0 || ifc.io_in_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL rm_drop: got valid=%b ready=%b, required 0/00", ifc.io_out_valid, ifc.io_in_ready);
    end
    next_cycle();
    reset_n = 1'b1;
    ifc.io_out_ready = 1'b1;
    push(0, ifc.io_in_bits[0]);
    #1;
    n_tests++;
    if (ifc.io_in_ready !== 2'b01) begin n_fail++; $display("FAIL rm_first: got %b, required 01", ifc.io_in_ready); end
    next_cycle();
    ifc.io_in_valid = 2'b00;
    wait_drain();
  endtask

`ifdef MEM_REQ_ARB_PERF_EN
  task automatic test_perf();
    logic [1:0] rdy_tab [6];
    rdy_tab[0] = 2'b10; rdy_tab[1] = 2'b00; rdy_tab[2] = 2'b00;
    rdy_tab[3] = 2'b00; rdy_tab[4] = 2'b01; rdy_tab[5] = 2'b10;
    next_cycle();
    ifc.io_in_valid = 2'b00;
    perf_clr = 1'b1;
    next_cycle();
    perf_clr = 1'b0;
    #1;
    n_tests++;
    if (perf_stall_cnt !== '0) begin n_fail++; $display("FAIL perf_init: got %h, required 0", perf_stall_cnt); end
    p0 = ifc.io_in_bits[0];
    p1 = ifc.io_in_bits[1];
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      ifc.io_in_valid = 2'b11;
      ifc.io_out_ready = (k >= 4) ? 1'b1 : 1'b0;
      if (rdy_tab[k] == 2'b01) push(0, p0);
      if (rdy_tab[k] == 2'b10) push(1, p1);
      #1;
      n_tests++;
      if (ifc.io_in_ready !== rdy_tab[k]) begin
        n_fail++;
        $display("FAIL perf_ready[%0d]: got %b, required %b", k, ifc.io_in_ready, rdy_tab[k]);
      end
    end
    next_cycle();
    ifc.io_out_ready = 1'b0;
    perf_clr = 1'b1;
    #1;
    n_tests++;
    if (perf_stall_cnt[0] !== 32'd5 || perf_stall_cnt[1] !== 32'd4) begin
      n_fail++;
      $display("FAIL perf_cnt: got %0d/%0d, required 5/4", perf_stall_cnt[0], perf_stall_cnt[1]);
    end
    next_cycle();
    perf_clr = 1'b0;
    ifc.io_in_valid = 2'b00;
    ifc.io_out_ready = 1'b1;
    #1;
    n_tests++;
    if (perf_stall_cnt !== '0) begin n_fail++; $display("FAIL perf_clr: got %h, required 0", perf_stall_cnt); end
    wait_drain();
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_alternate();
    test_single();
    test_backpressure();
    test_payload();
    test_reset_mid();
`ifdef MEM_REQ_ARB_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_req_rr_arbiter.md
# mem_req_rr_arbiter

Registered round-robin arbiter that shares one memory-request port among `NUM_IN` requesters (e.g., core D-cache port, page-table walker, RoCC/accelerator port). It carries the standard request bundle (addr 40b, tag 10b, cmd 5b, typ 3b, kill, phys, data 64b). It replaces fixed-priority combinational selection with fair arbitration and a one-entry output pipeline register that cuts the ready/valid timing path.

## Interface
- `NUM_IN`, default 2: number of requesters; legal range 2..4.
- `IDX_W`, default 1: derived; width of `io_chosen` = `$clog2(NUM_IN)`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  reset; asynchronous assert, active-low, synchronous deassert by the system.
- `io_in_valid`  in  `NUM_IN`  per-requester request valid.
- `io_in_ready`  out  `NUM_IN`  per-requester accept.
- `io_in_bits`  in  `NUM_IN` x 124  per-requester `mem_req_t` payload.
- `io_out_valid`  out  1  registered request valid.
- `io_out_ready`  in  1  downstream accept.
- `io_out_bits`  out  124  registered `mem_req_t` payload.
- `io_chosen`  out  `IDX_W`  index of the requester whose request is in `io_out_bits`.
- `perf_clr`  in  1  clears stall counters; present only with `MEM_REQ_ARB_PERF_EN`.
- `perf_stall_cnt`  out  `NUM_IN` x 32  per-requester stall counters; present only with `MEM_REQ_ARB_PERF_EN`.

## Operation
- State:
  - output register: `out_valid`, `out_bits`, `out_chosen`.
  - `last_grant` pointer, `IDX_W` bits.
- Reset values:
  - `io_out_valid`=0, `io_out_bits`=0, `io_chosen`=0.
  - `last_grant`=`NUM_IN-1`, so requester 0 has top priority first.
  - all stall counters 0.
  - `io_in_ready` is 0 while `reset_n` is low.
- `can_load` = `!out_valid || io_out_ready`.
- Arbitration (combinational):
  - search the valid requesters starting at `last_grant+1`, wrapping modulo `NUM_IN`.
  - the first valid requester found is `grant`.
  - if no requester is valid, nothing is granted.
- `io_in_ready[i]` = `can_load && grant==i && io_in_valid[i]`. At most one ready bit is high in a cycle.
- Load: when a requester fires (`valid && ready`), the output register captures its payload and `out_chosen`=i, and `last_grant` becomes i.
- Pointer hold: `last_grant` changes only on a fire. Pending valids with a stalled output never move the pointer.
- Output drain: when `io_out_valid && io_out_ready` and no new fire occurs, `out_valid` clears.
- Simultaneous drain and fire: the register is overwritten with the new request and `out_valid` stays 1. This gives full throughput.
- Payload is passed unmodified, including `kill` and `phys`. Kill semantics belong downstream.
- Requester obligation: a requester holds `valid` and its payload stable until accepted. The arbiter does not check this.

## Timing
- Latency: 1 cycle from input fire to `io_out_valid`.
- Throughput: one request per cycle while `io_out_ready`=1.
- No combinational path from `io_in_*` to `io_out_*`.
- One combinational path exists, `io_out_ready` -> `io_in_ready`. It is a single AND level after arbitration.
- Fairness: with all `NUM_IN` requesters continuously valid, each is granted exactly once every `NUM_IN` fires.
- Reset mid-transfer: the output register is discarded immediately and the pointer returns to `NUM_IN-1`.

## Configuration
- `MEM_REQ_ARB_PERF_EN` defined:
  - adds `perf_clr` and `perf_stall_cnt`.
  - counter i increments each cycle `io_in_valid[i] && !io_in_ready[i]`.
  - counters saturate at `32'hFFFF_FFFF`.
  - `perf_clr` has priority over increment; counters read 0 the cycle after `perf_clr`.
- Undefined: both ports and all counter logic are absent; arbitration is identical.

## Structure
- Package `mem_req_pkg`:
  - constants `ADDR_W`=40, `TAG_W`=10, `CMD_W`=5, `TYP_W`=3, `DATA_W`=64.
  - packed struct `mem_req_t` with fields {addr, tag, cmd, typ, kill, phys, data}, 124 bits.
- Sub-module `rr_pick`: combinational round-robin priority picker, inputs `req[NUM_IN]` and `last`, outputs `grant_idx` and `any`. It is reusable by other arbiters.

## Test plan
- Reset, no requests: all outputs 0; after deassert, `io_in_valid`=2'b11 with `io_out_ready`=1 -> in0 accepted first (`io_chosen`=0 next cycle), then in1, alternating 0,1,0,1.
- Single requester: in1 alone streams addr 0x100, 0x108, 0x110 with `io_out_ready`=1 -> three consecutive output beats, `io_chosen`=1, same order, no bubbles.
- Backpressure: output register full, `io_out_ready`=0 for 5 cycles with both valid -> both `io_in_ready`=0 and `last_grant` unchanged; on release the next grant goes to the other requester.
- Payload integrity: in0 sends tag=0x3FF, cmd=5'h1F, kill=1, phys=1, data=0xDEADBEEF_CAFEF00D -> `io_out_bits` matches bit-exactly one cycle later.
- Reset mid-stream: assert `reset_n`=0 while `io_out_valid`=1 -> `io_out_valid` drops to 0 immediately; after release, in0 wins first.
- `MEM_REQ_ARB_PERF_EN`: hold in1 valid while in0 streams 4 grants and `io_out_ready`=0 stalls 3 cycles -> `perf_stall_cnt[1]` reflects every blocked cycle; `perf_clr` pulse -> 0.
